// File: rtl/mcp_pkg.sv
// Shared types and constants for the MCP-formulation clock-domain-crossing blocks.
package mcp_pkg;

  localparam int BUS_LEN = 40;

  typedef enum logic {
    S_IDLE,
    S_WAIT_ACK
  } mcp_send_state_t;

  typedef logic [BUS_LEN-1:0] mcp_word_t;

endpackage

// File: rtl/mcp_sync_bit.sv
// Multi-flop single-bit synchroniser; shared by the send and receive sides.
module mcp_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; clear on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mcp_send_fifo.sv
// Source-domain half of the MCP CDC transfer: a small FIFO whose head word is
// announced by toggling a_en and popped when the synchronised b_ack toggles.
module mcp_send_fifo
  import mcp_pkg::*;
#(
  parameter int DATA_W      = BUS_LEN,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic [DATA_W-1:0]          adatain,
  input  logic                       asend,
  output logic                       aready,
  output logic [DATA_W-1:0]          adata,
  output logic                       a_en,
  input  logic                       b_ack,
  output logic [$clog2(DEPTH+1)-1:0] afill,
  output logic                       aovf,
  output logic                       aack_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  issue_ptr;
  logic [CNT_W-1:0]  count;

  mcp_send_state_t state;
  mcp_send_state_t state_nxt;

  logic ack_s;
  logic ack_prev;
  logic ack_evt;
  logic wr_en;
  logic pop;
  logic issue;

  // The head word stays counted until acknowledged, so fullness is judged on count alone.
  assign aready  = (count != CNT_W'(DEPTH));
  assign wr_en   = asend && aready;
  assign ack_evt = ack_s ^ ack_prev;
  assign afill   = count;

  mcp_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (aclk),
    .rst (arst),
    .d   (b_ack),
    .q   (ack_s)
  );

  // Decide whether this edge pops the outstanding word and/or issues a new one.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    issue_ptr = rd_ptr;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          issue     = 1'b1;
          state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (ack_evt) begin
          pop = 1'b1;
          // Another word is already queued behind the head: issue it on this same edge.
          if (count != CNT_W'(1)) begin
            issue     = 1'b1;
            issue_ptr = rd_ptr + PTR_W'(1);
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge aclk) begin
    // NOTE: the storage array is deliberately not reset; count and pointers alone define validity.
    if (wr_en) mem[wr_ptr] <= adatain;
  end

  // Pointers, occupancy, FSM state, crossing outputs and sticky flags.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ack_prev <= 1'b0;
      adata    <= '0;
      a_en     <= 1'b0;
      aovf     <= 1'b0;
      aack_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_prev <= ack_s;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // adata only changes together with a toggle, so it is stable while a word is outstanding.
      if (issue) begin
        adata <= mem[issue_ptr];
        a_en  <= ~a_en;
      end
      if (asend && !aready)           aovf     <= 1'b1;
      if (state == S_IDLE && ack_evt) aack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcp_send_fifo.sv
// Self-checking bench for mcp_send_fifo: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mcp_send_fifo;

  localparam int DW    = 40;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          aclk = 1'b0;
  logic          arst = 1'b1;
  logic [DW-1:0] adatain = '0;
  logic          asend = 1'b0;
  logic          aready;
  logic [DW-1:0] adata;
  logic          a_en;
  logic          b_ack = 1'b0;
  logic [CW-1:0] afill;
  logic          aovf;
  logic          aack_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int en_toggles = 0;
  logic en_last = 1'b0;

  mcp_send_fifo #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .aclk     (aclk),
    .arst     (arst),
    .adatain  (adatain),
    .asend    (asend),
    .aready   (aready),
    .adata    (adata),
    .a_en     (a_en),
    .b_ack    (b_ack),
    .afill    (afill),
    .aovf     (aovf),
    .aack_err (aack_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: queue of words (head = outstanding word), expected outputs,
  // and a record of b_ack samples so an ack is seen SS+1 edges after it is sampled.
  logic [DW-1:0] mq[$];
  bit            m_out = 1'b0;
  logic [DW-1:0] m_adata = '0;
  bit            m_en = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_err = 1'b0;
  bit            hist [1:SS+1];
  bit            m_evt;
  int            m_pre;

  initial for (int k = 1; k <= SS+1; k++) hist[k] = 1'b0;

  always @(posedge aclk) begin
    m_evt = hist[SS] ^ hist[SS+1];
    m_pre = mq.size();
    if (arst) begin
      mq.delete();
      m_out = 1'b0; m_adata = '0; m_en = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      for (int k = 1; k <= SS+1; k++) hist[k] = 1'b0;
    end else begin
      if (m_out) begin
        if (m_evt) begin
          void'(mq.pop_front());
          if (m_pre > 1) begin
            m_adata = mq[0];
            m_en    = ~m_en;
          end else begin
            m_out = 1'b0;
          end
        end
      end else begin
        if (m_evt) m_err = 1'b1;
        if (m_pre != 0) begin
          m_adata = mq[0];
          m_en    = ~m_en;
          m_out   = 1'b1;
        end
      end
      if (asend) begin
        if (m_pre < DEPTH) mq.push_back(adatain);
        else               m_ovf = 1'b1;
      end
      for (int k = SS+1; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = b_ack;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge aclk) begin
    if (chk_on) begin
      check("model adata",    adata,    m_adata);
      check("model a_en",     a_en,     m_en);
      check("model afill",    afill,    mq.size());
      check("model aready",   aready,   mq.size() != DEPTH);
      check("model aovf",     aovf,     m_ovf);
      check("model aack_err", aack_err, m_err);
    end
  end

  // Count a_en transitions.
  always @(negedge aclk) begin
    if (a_en !== en_last) en_toggles++;
    en_last = a_en;
  end

  task automatic do_reset(input int cycles);
    arst  = 1'b1;
    b_ack = 1'b0;
    asend = 1'b0;
    repeat (cycles) @(negedge aclk);
    arst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    asend   = 1'b1;
    adatain = w;
    @(negedge aclk);
    asend   = 1'b0;
  endtask

  task automatic wait_fill(input int target, input int budget, output int cycles);
    cycles = 0;
    while (afill != CW'(target) && cycles < budget) begin
      @(negedge aclk);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    logic [DW-1:0] w;

    // Reset
    @(negedge aclk);
    do_reset(2);
    chk_on = 1'b1;
    check("rst a_en", a_en, 0);
    check("rst adata", adata, 0);
    check("rst afill", afill, 0);
    check("rst aready", aready, 1);
    check("rst aovf", aovf, 0);
    check("rst aack_err", aack_err, 0);

    // Single word
    push(40'hA5_1234_5678);
    @(negedge aclk);
    check("single adata", adata, 40'hA5_1234_5678);
    check("single a_en", a_en, 1);
    check("single afill", afill, 1);
    b_ack = ~b_ack;
    wait_fill(0, 8, cyc);
    check("single drained", afill, 0);
    check("single ack latency ok", (cyc >= SS+1 && cyc <= SS+2), 1);
    check("single a_en held", a_en, 1);
    @(negedge aclk);
    check("single idle a_en", a_en, 1);

    // Overflow
    do_reset(2);
    for (int i = 1; i <= 5; i++) begin
      push(DW'(i));
      if (i == 4) check("ovf aready after 4th", aready, 0);
    end
    check("ovf aovf", aovf, 1);
    check("ovf afill", afill, 4);
    check("ovf head", adata, 1);
    for (int k = 1; k <= 4; k++) begin
      b_ack = ~b_ack;
      wait_fill(4-k, 8, cyc);
      check("ovf fill after ack", afill, 4-k);
      if (k < 4) check("ovf adata seq", adata, k+1);
    end
    check("ovf last word", adata, 4);

    // Back-to-back
    do_reset(2);
    en_toggles = 0;
    push(40'h11); push(40'h22); push(40'h33);
    check("b2b first", adata, 40'h11);
    for (int k = 1; k <= 3; k++) begin
      b_ack = ~b_ack;
      wait_fill(3-k, 8, cyc);
      check("b2b fill", afill, 3-k);
      w = (k == 1) ? 40'h22 : 40'h33;
      check("b2b adata", adata, w);
    end
    repeat (4) @(negedge aclk);
    check("b2b toggles", en_toggles, 3);

    // Spurious ack
    do_reset(2);
    b_ack = ~b_ack;
    repeat (SS) @(negedge aclk);
    check("spur err not yet", aack_err, 0);
    @(negedge aclk);
    check("spur err", aack_err, 1);
    check("spur afill", afill, 0);
    check("spur a_en", a_en, 0);

    // Reset mid-transfer
    do_reset(2);
    push(40'h55); push(40'h66);
    check("mid a_en", a_en, 1);
    check("mid afill", afill, 2);
    do_reset(1);
    check("mid rst afill", afill, 0);
    check("mid rst a_en", a_en, 0);
    check("mid rst adata", adata, 0);
    check("mid rst aready", aready, 1);
    push(40'h77);
    @(negedge aclk);
    check("mid new adata", adata, 40'h77);
    check("mid new a_en", a_en, 1);
    b_ack = ~b_ack;
    wait_fill(0, 8, cyc);
    check("mid new drained", afill, 0);
    check("mid no ack err", aack_err, 0);

    @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
